// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit: radix-2 Booth multiply and
// restoring divide, fixed 33-cycle latency from the accepting edge to RDY.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int W = WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic           qm1_q, qm1_d;
    logic [W-1:0]   m_q, m_d;
    logic           neg_q, neg_d;
    logic           dz_q, dz_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   result_q, result_d;
    logic           exc_q, exc_d;
    logic           rdy_q, rdy_d;
    logic           busy_q, busy_d;
    logic [2*W:0]   booth_s;
    logic           mul_ovf_s;

    function automatic logic [W-1:0] abs_val(input logic [W-1:0] x);
        if (x[W-1]) begin
            return (~x) + {{(W-1){1'b0}}, 1'b1};
        end else begin
            return x;
        end
    endfunction

    // One Booth step: 33-bit partial sum keeps -M representable when M is the most negative value.
    // Result is {new_acc, new_qm1} after the arithmetic right shift.
    function automatic logic [2*W:0] booth_step(input logic [2*W-1:0] acc,
                                                input logic           qm1,
                                                input logic [W-1:0]   m);
        logic [W:0] hi_ext;
        logic [W:0] m_ext;
        logic [W:0] sum;
        hi_ext = {acc[2*W-1], acc[2*W-1:W]};
        m_ext  = {m[W-1], m};
        case ({acc[0], qm1})
            2'b01:   sum = hi_ext + m_ext;
            2'b10:   sum = hi_ext - m_ext;
            default: sum = hi_ext;
        endcase
        return {sum, acc[W-1:0]};
    endfunction

    // One restoring-division step on {remainder, quotient}; remainder < divisor keeps the shift in W bits.
    function automatic logic [2*W-1:0] div_step(input logic [2*W-1:0] acc,
                                                input logic [W-1:0]   d);
        logic [2*W-1:0] sh;
        logic [W:0]     diff;
        sh   = {acc[2*W-2:0], 1'b0};
        diff = {1'b0, sh[2*W-1:W]} - {1'b0, d};
        if (!diff[W]) begin
            return {diff[W-1:0], sh[W-1:1], 1'b1};
        end else begin
            return sh;
        end
    endfunction

    assign booth_s   = booth_step(acc_q, qm1_q, m_q);
    assign mul_ovf_s = ~((&acc_q[2*W-1:W-1]) | ~(|acc_q[2*W-1:W-1]));

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ctrl_MULT) begin
                    state_d = S_MUL;
                    cnt_d   = 6'd0;
                    acc_d   = {{W{1'b0}}, data_operandB};
                    qm1_d   = 1'b0;
                    m_d     = data_operandA;
                    neg_d   = 1'b0;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                end else if (ctrl_DIV) begin
                    state_d = S_DIV;
                    cnt_d   = 6'd0;
                    acc_d   = {{W{1'b0}}, abs_val(data_operandA)};
                    qm1_d   = 1'b0;
                    m_d     = abs_val(data_operandB);
                    neg_d   = data_operandA[W-1] ^ data_operandB[W-1];
                    dz_d    = (data_operandB == {W{1'b0}});
                    ovf_d   = (data_operandA == {1'b1, {(W-1){1'b0}}}) &&
                              (data_operandB == {W{1'b1}});
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (cnt_q == 6'd32) begin
                    state_d  = S_DONE;
                    result_d = acc_q[W-1:0];
                    exc_d    = mul_ovf_s;
                end else begin
                    acc_d = booth_s[2*W:1];
                    qm1_d = booth_s[0];
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DIV: begin
                if (cnt_q == 6'd32) begin
                    state_d = S_DONE;
                    if (dz_q) begin
                        result_d = {W{1'b0}};
                        exc_d    = 1'b1;
                    end else if (ovf_q) begin
                        // |min| / 1 already yields the min pattern, so no negation here.
                        result_d = acc_q[W-1:0];
                        exc_d    = 1'b1;
                    end else if (neg_q) begin
                        result_d = (~acc_q[W-1:0]) + {{(W-1){1'b0}}, 1'b1};
                        exc_d    = 1'b0;
                    end else begin
                        result_d = acc_q[W-1:0];
                        exc_d    = 1'b0;
                    end
                end else begin
                    acc_d = div_step(acc_q, m_q);
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        rdy_d  = (state_d == S_DONE);
        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= {(2*W){1'b0}};
            qm1_q    <= 1'b0;
            m_q      <= {W{1'b0}};
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= {W{1'b0}};
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed 32-bit multiply/divide responder for the processor's multicycle ALU path. The processor initiates with a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse carrying both operands. This block latches the operands and runs a fixed 32-step shift-add or shift-subtract sequence. It then returns the result with a one-cycle `data_resultRDY` pulse and a `data_exception` flag. It sits beside the ALU inside `processor`; the pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and result width; only 32 is supported.
- `clock` input 1: master clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; 0 forces the reset state immediately.
- `data_operandA` input 32: multiplicand or dividend, two's complement; sampled only on an accepted request.
- `data_operandB` input 32: multiplier or divisor, two's complement; sampled only on an accepted request.
- `ctrl_MULT` input 1: start-multiply pulse.
- `ctrl_DIV` input 1: start-divide pulse.
- `data_result` output 32: low 32 bits of the product, or the quotient (truncated toward zero).
- `data_exception` output 1: overflow or divide-by-zero for the completed operation.
- `data_resultRDY` output 1: one-cycle completion pulse.
- `busy` output 1: high while an operation is in flight.

## Operation
- **States:** IDLE, MUL, DIV, DONE; 6-bit step counter; 64-bit working register (product, or remainder:quotient).
- **Reset values (reset=0):** state IDLE, counter 0, `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
- **Accepting a request:**
  - A request is accepted in IDLE or DONE when `ctrl_MULT` or `ctrl_DIV` is 1 at a rising edge.
  - On acceptance the block latches the operands, clears the counter and enters MUL or DIV.
  - If both controls are 1, `ctrl_MULT` wins.
  - Requests in MUL or DIV are ignored, with no effect on the in-flight operation.
- **MUL:**
  - Radix-2 Booth on the latched operands, one step per cycle, 32 steps.
  - The exception condition is the full 64-bit signed product not fitting in 32 bits (bits 63:31 not all equal).
  - On exception, the result is still the low 32 bits.
- **DIV:**
  - Restoring division on operand magnitudes, one quotient bit per cycle, 32 steps.
  - The quotient is negated when the operand signs differ.
  - The remainder is discarded.
  - Divisor 0 produces `data_exception`=1 and `data_result`=0.
  - 0x80000000 / -1 produces `data_exception`=1 and `data_result`=0x80000000.
  - Both special cases use the same fixed latency as a normal divide.
- **Completion:**
  - After step 32 the block enters DONE and loads `data_result` and `data_exception`.
  - `data_resultRDY` is 1 for the DONE cycle only.
  - In the DONE cycle, with no new request, the block returns to IDLE.
- **Output hold:** `data_result` and `data_exception` hold until the next completion or reset. They do not change during a subsequent operation.
- **`busy`:** 1 in MUL and DIV, 0 in IDLE and DONE.
- **Operand inputs:** may change freely after the accepting edge.

## Timing
- **Acceptance (edge 0):** the request is sampled at rising edge 0, and `busy` rises after edge 0.
- **Iteration:** edges 1 through 32 each perform one step.
- **Completion (edge 33):** state becomes DONE; `data_result`, `data_exception` and `data_resultRDY` update after edge 33 and are valid for that cycle.
- **Latency:** fixed at 33 cycles from the accepting edge to RDY, for both MUL and DIV, including exception cases.
- **Back-to-back:** a request present during the DONE cycle is accepted at edge 34. RDY still pulses for exactly one cycle, and the new operation completes at edge 67.
- **Reset mid-operation:**
  - All outputs go to their reset values immediately (asynchronous), with no RDY pulse.
  - After reset releases, the first accepted request behaves as from IDLE.
- **Request timing from processor:** a request asserted coincident with reset release is ignored if reset is still 0 at the edge.
- **RDY pulse width:** never wider than one cycle; RDY and `busy` are never 1 together.

## Test plan
- **Signed multiply:** A=7, B=-3, `ctrl_MULT` pulse -> `busy`=1 for 33 cycles; RDY after edge 33 with result 0xFFFFFFEB, exception 0. RDY is low the next cycle and the result is held.
- **Multiply overflow:** A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. A=-65536, B=32768 -> result 0x80000000, exception 0.
- **Divide:**
  - -7/2 -> 0xFFFFFFFD, exception 0.
  - 100/-7 -> 0xFFFFFFF2.
  - 5/0 -> 0, exception 1.
  - 0x80000000/-1 -> 0x80000000, exception 1.
  - All complete at edge 33.
- **Ignored requests:**
  - Start MUL 3*4.
  - Pulse `ctrl_DIV` with A=9, B=3 at edge 10 -> no effect; result is 12 at edge 33.
  - Assert MULT and DIV together with A=6, B=2 -> result 12 (multiply).
- **Back-to-back:** issue 6/3 in the DONE cycle of a prior 5*5 -> result 25 at edge 33, then 2 at edge 67; exactly two single-cycle RDY pulses.
- **Reset mid-operation:** drive reset=0 at cycle 15 of a multiply -> all outputs 0 asynchronously and no RDY. After release, 2*2 -> 4 at edge 33 relative to its accepting edge.
